mpu_scalar_mul_seq: RTL and testbench
=====================================

// Module: mpu_scalar_mul_seq
// PURPOSE
//   Sequenced scalar-multiply engine for the MPU. Multiplies every element of a 5x5 signed
//   8-bit matrix by a signed 8-bit factor, LANES elements per cycle, using shared multiplier lanes.
//   Start/busy/done handshake toward the MPU instruction controller.
//   Flattened matrix layout: element (col,row) at bit offset 8*(row+5*col).
// PARAMETERS
//   LANES     5  elements multiplied per cycle; legal values 1, 5, 25; beats = 25/LANES
//   SATURATE  0  0: wrap to 8 bits (two's-complement truncation); 1: clamp to [-128,127]
// PORTS
//   clock         in   1    system clock, all logic on rising edge
//   reset         in   1    synchronous, active-high
//   start         in   1    request; accepted only in IDLE
//   matrix_a      in   200  signed 5x5 8-bit operand, sampled on the accept edge only
//   factor        in   8    signed scalar, sampled on the accept edge only
//   busy          out  1    operation in progress
//   done          out  1    one-cycle pulse: result complete
//   result_valid  out  1    result holds a complete product
//   overflow      out  1    some element product exceeded the 8-bit signed range (this op)
//   result        out  200  signed 5x5 8-bit product matrix
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, done=0, result_valid=0, overflow=0, result=0, beat=0.
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 at edge N -> latch matrix_a, factor; beat=0; busy=1; result_valid=0;
//     overflow=0; go to RUN. result is not cleared.
//   RUN: each edge writes elements [beat*LANES, beat*LANES+LANES-1] of result
//     (LANES=5: one column per beat); beat increments. After the last beat
//     (edge N+25/LANES): busy=0, done=1, result_valid=1, go to DONE.
//   DONE: lasts one cycle; done=0 at next edge; back to IDLE. start seen in DONE is ignored.
//   Latency: done is high during the cycle after edge N+25/LANES (LANES=5: N+5; 1: N+25; 25: N+1).
//   start during RUN/DONE is ignored; no queueing. The latched operands are used throughout RUN;
//     changes on matrix_a/factor after accept have no effect.
//   Arithmetic: full product is 16-bit signed; ovf_elem = product outside [-128,127].
//     SATURATE=0 -> low 8 bits; SATURATE=1 -> clamp. overflow |= ovf_elem of every lane, every beat
//     (sticky for the op, cleared on next accept).
//   result_valid falls on the next accept edge. result is read only while result_valid=1.
//   Reset mid-RUN: immediate return to reset state at that edge; no done pulse.
//   reset and start high on the same edge: reset wins.
//   Back-to-back: start held high -> re-accepted on the first IDLE edge after DONE
//     (LANES=5: ops accepted every 7 cycles).
// STRUCTURE
//   mpu_pkg: MPU_DIM=5, ELEM_W=8, MATRIX_W=200, ELEMS=25, state enum {IDLE,RUN,DONE},
//     function elem_off(col,row)=8*(row+5*col).
//   Sub-module mpu_mul_lane: one signed 8x8 multiply, SATURATE param, outputs res[7:0], ovf.
//     Instantiated LANES times by generate.
//   Top: FSM, beat counter ($clog2(25/LANES) bits, min 1), operand regs, result/flag regs.
// TESTING
//   1 LANES=5, A(c,r)=r+5c (0..24), factor=2 -> done 5 cycles after accept, result(c,r)=2(r+5c),
//     overflow=0.
//   2 A all 100, factor=2, SATURATE=0 -> all elements -56 (0xC8), overflow=1; SATURATE=1 -> all 127.
//   3 A all -128, factor=-1 -> SATURATE=0: -128, overflow=1; SATURATE=1: 127. Factor=0 -> all 0,
//     overflow=0.
//   4 start pulsed at accept+2, and matrix_a changed to 0 at accept+1 -> ignored; only one done;
//     result from the original operands.
//   5 reset asserted at accept+3 -> next cycle busy=0, done=0, result_valid=0, result=0;
//     no done pulse afterwards.
//   6 start held high, LANES=1/5/25 -> done spacing 27/7/3 cycles; a reference model matches
//     every element.

Source files
------------

// File: rtl/mpu_pkg.sv
// rtl/mpu_pkg.sv - shared MPU matrix geometry, FSM state type and element offset helper
package mpu_pkg;

    localparam int MPU_DIM  = 5;
    localparam int ELEM_W   = 8;
    localparam int ELEMS    = MPU_DIM * MPU_DIM;
    localparam int MATRIX_W = ELEMS * ELEM_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit offset of element (col,row) in a flattened matrix.
    function automatic int elem_off(input int col, input int row);
        return ELEM_W * (row + MPU_DIM * col);
    endfunction

endpackage

// File: rtl/mpu_mul_lane.sv
// rtl/mpu_mul_lane.sv - one signed 8x8 multiply lane with wrap or saturate to 8 bits
//   a, b : signed 8-bit operands
//   res  : 8-bit result (wrapped or clamped per SATURATE)
//   ovf  : full 16-bit product lies outside [-128,127]
module mpu_mul_lane
    import mpu_pkg::*;
#(
    parameter bit SATURATE = 1'b0
) (
    input  logic signed [ELEM_W-1:0] a,
    input  logic signed [ELEM_W-1:0] b,
    output logic        [ELEM_W-1:0] res,
    output logic                     ovf
);

    localparam logic signed [2*ELEM_W-1:0] P_MAX = 16'sd127;
    localparam logic signed [2*ELEM_W-1:0] P_MIN = -16'sd128;

    logic signed [2*ELEM_W-1:0] prod;

    assign prod = a * b;

    always_comb begin
        ovf = (prod > P_MAX) || (prod < P_MIN);
        res = prod[ELEM_W-1:0];
        if (SATURATE && ovf) begin
            res = prod[2*ELEM_W-1] ? 8'h80 : 8'h7F;
        end
    end

endmodule

// File: rtl/mpu_scalar_mul_seq.sv
// rtl/mpu_scalar_mul_seq.sv - sequenced 5x5 matrix by scalar multiply over LANES shared lanes
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start               : request, accepted only in IDLE
//   matrix_a, factor    : operands, captured on the accept edge
//   busy, done          : op in progress / one-cycle completion pulse
//   result_valid        : result holds a complete product
//   overflow            : sticky per-op element overflow flag
//   result              : product matrix, element (col,row) at bit 8*(row+5*col)
module mpu_scalar_mul_seq
    import mpu_pkg::*;
#(
    parameter int LANES    = 5,    // 1, 5 or 25
    parameter bit SATURATE = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [MATRIX_W-1:0] matrix_a,
    input  logic [ELEM_W-1:0]   factor,
    output logic                busy,
    output logic                done,
    output logic                result_valid,
    output logic                overflow,
    output logic [MATRIX_W-1:0] result
);

    localparam int BEATS  = ELEMS / LANES;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LANE_W = ELEM_W * LANES;

    state_t                state;
    logic [BW-1:0]         beat;
    logic [MATRIX_W-1:0]   a_reg;
    logic [ELEM_W-1:0]     f_reg;
    logic [LANE_W-1:0]     a_lane;
    logic [ELEM_W-1:0]     lane_res [LANES];
    logic [LANES-1:0]      lane_ovf;
    logic                  last_beat;

    // Elements of the current beat are contiguous in the flattened layout,
    // so shifting the latched matrix down presents them to lanes 0..LANES-1.
    assign a_lane    = LANE_W'(a_reg >> (32'(beat) * LANE_W));
    assign last_beat = (beat == BW'(BEATS - 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mpu_mul_lane #(
            .SATURATE(SATURATE)
        ) u_lane (
            .a  (a_lane[l*ELEM_W +: ELEM_W]),
            .b  (f_reg),
            .res(lane_res[l]),
            .ovf(lane_ovf[l])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            beat         <= '0;
            a_reg        <= '0;
            f_reg        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            result       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg        <= matrix_a;
                        f_reg        <= factor;
                        beat         <= '0;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                        overflow     <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        result[ELEM_W*(int'(beat)*LANES + l) +: ELEM_W] <= lane_res[l];
                    end
                    overflow <= overflow | (|lane_ovf);
                    if (last_beat) begin
                        beat         <= '0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_scalar_mul_seq.sv
// tb/tb_mpu_scalar_mul_seq.sv - randomized model-checked bench over four LANES/SATURATE configs
module tb_mpu_scalar_mul_seq;
    import mpu_pkg::*;

    localparam int NI = 4;
    localparam int LN  [NI] = '{5, 5, 1, 25};
    localparam bit SAT [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};
    localparam int SPACING [NI] = '{7, 7, 27, 3};

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [MATRIX_W-1:0] matrix_a = '0;
    logic [ELEM_W-1:0]   factor = '0;

    logic                busy_o  [NI];
    logic                done_o  [NI];
    logic                valid_o [NI];
    logic                ovf_o   [NI];
    logic [MATRIX_W-1:0] res_o   [NI];

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    mpu_scalar_mul_seq #(.LANES(5), .SATURATE(1'b0)) u_dut0 (
        .clock(clock), .reset(reset), .start(start), .matrix_a(matrix_a), .factor(factor),
        .busy(busy_o[0]), .done(done_o[0]), .result_valid(valid_o[0]), .overflow(ovf_o[0]),
        .result(res_o[0]));
    mpu_scalar_mul_seq #(.LANES(5), .SATURATE(1'b1)) u_dut1 (
        .clock(clock), .reset(reset), .start(start), .matrix_a(matrix_a), .factor(factor),
        .busy(busy_o[1]), .done(done_o[1]), .result_valid(valid_o[1]), .overflow(ovf_o[1]),
        .result(res_o[1]));
    mpu_scalar_mul_seq #(.LANES(1), .SATURATE(1'b0)) u_dut2 (
        .clock(clock), .reset(reset), .start(start), .matrix_a(matrix_a), .factor(factor),
        .busy(busy_o[2]), .done(done_o[2]), .result_valid(valid_o[2]), .overflow(ovf_o[2]),
        .result(res_o[2]));
    mpu_scalar_mul_seq #(.LANES(25), .SATURATE(1'b1)) u_dut3 (
        .clock(clock), .reset(reset), .start(start), .matrix_a(matrix_a), .factor(factor),
        .busy(busy_o[3]), .done(done_o[3]), .result_valid(valid_o[3]), .overflow(ovf_o[3]),
        .result(res_o[3]));

    // ---------------- reference model ----------------
    int                  since    [NI];
    bit                  exp_busy [NI];
    bit                  exp_done [NI];
    bit                  exp_valid[NI];
    bit                  exp_ovf  [NI];
    bit                  pend_ovf [NI];
    bit                  res_known[NI];
    logic [MATRIX_W-1:0] exp_res  [NI];
    logic [MATRIX_W-1:0] pend_res [NI];
    bit                  model_on = 1'b0;

    task automatic compute(input logic [MATRIX_W-1:0] a, input logic [7:0] f, input bit sat,
                           output logic [MATRIX_W-1:0] r, output bit o);
        int p;
        r = '0;
        o = 1'b0;
        for (int k = 0; k < ELEMS; k++) begin
            p = int'($signed(a[8*k +: 8])) * int'($signed(f));
            if (p > 127 || p < -128) o = 1'b1;
            if (sat && p > 127)       r[8*k +: 8] = 8'h7F;
            else if (sat && p < -128) r[8*k +: 8] = 8'h80;
            else                      r[8*k +: 8] = 8'(p);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_on = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (reset) begin
                    since[i] = -1;
                    exp_busy[i] = 0; exp_done[i] = 0; exp_valid[i] = 0; exp_ovf[i] = 0;
                    exp_res[i] = '0; res_known[i] = 1;
                end else if (since[i] < 0 || since[i] > 25 / LN[i]) begin
                    exp_done[i] = 0;
                    if (start) begin
                        compute(matrix_a, factor, SAT[i], pend_res[i], pend_ovf[i]);
                        since[i] = 0;
                        exp_busy[i] = 1; exp_valid[i] = 0; exp_ovf[i] = 0; res_known[i] = 0;
                    end
                end else begin
                    since[i]++;
                    if (since[i] == 25 / LN[i]) begin
                        exp_busy[i] = 0; exp_done[i] = 1; exp_valid[i] = 1;
                        exp_res[i] = pend_res[i]; exp_ovf[i] = pend_ovf[i]; res_known[i] = 1;
                    end else if (since[i] == 25 / LN[i] + 1) begin
                        exp_done[i] = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int inst, input logic [MATRIX_W-1:0] got,
                       input logic [MATRIX_W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s inst%0d at %0t: got %0h required %0h", name, inst, $time, got, exp);
        end
    endtask

    // compare process: every cycle, against the model
    initial begin
        forever begin
            @(negedge clock);
            if (model_on) begin
                for (int i = 0; i < NI; i++) begin
                    chk("busy", i, MATRIX_W'(busy_o[i]), MATRIX_W'(exp_busy[i]));
                    chk("done", i, MATRIX_W'(done_o[i]), MATRIX_W'(exp_done[i]));
                    chk("result_valid", i, MATRIX_W'(valid_o[i]), MATRIX_W'(exp_valid[i]));
                    if (!exp_busy[i]) chk("overflow", i, MATRIX_W'(ovf_o[i]), MATRIX_W'(exp_ovf[i]));
                    if (res_known[i]) chk("result", i, res_o[i], exp_res[i]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int lat [NI];
    int dt  [NI][$];
    logic [MATRIX_W-1:0] m;

    function automatic logic [7:0] el(input logic [MATRIX_W-1:0] x, input int off);
        return x[off +: 8];
    endfunction

    task automatic run_op(input logic [MATRIX_W-1:0] a, input logic [7:0] f);
        @(posedge clock); #1;
        matrix_a = a; factor = f; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < NI; i++) lat[i] = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            for (int i = 0; i < NI; i++) if (done_o[i] && lat[i] < 0) lat[i] = c;
            @(posedge clock);
        end
        #1;
    endtask

    task automatic count_done(input int cycles, output int cnt0, output int cnt2);
        cnt0 = 0; cnt2 = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            if (done_o[0]) cnt0++;
            if (done_o[2]) cnt2++;
        end
    endtask

    initial begin
        int c0, c2;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // 1: ramp matrix, factor 2
        for (int k = 0; k < ELEMS; k++) m[8*k +: 8] = 8'(k);
        run_op(m, 8'd2);
        chk("lat_l5", 0, MATRIX_W'(lat[0]), MATRIX_W'(5));
        chk("lat_l1", 2, MATRIX_W'(lat[2]), MATRIX_W'(25));
        chk("lat_l25", 3, MATRIX_W'(lat[3]), MATRIX_W'(1));
        chk("ramp_c2r3", 0, MATRIX_W'(el(res_o[0], elem_off(2, 3))), MATRIX_W'(26));
        chk("ramp_c4r4", 2, MATRIX_W'(el(res_o[2], elem_off(4, 4))), MATRIX_W'(48));
        chk("ramp_ovf", 0, MATRIX_W'(ovf_o[0]), '0);

        // 2: all 100 times 2
        for (int k = 0; k < ELEMS; k++) m[8*k +: 8] = 8'd100;
        run_op(m, 8'd2);
        chk("wrap100", 0, MATRIX_W'(el(res_o[0], elem_off(1, 2))), MATRIX_W'(8'hC8));
        chk("wrap100_ovf", 0, MATRIX_W'(ovf_o[0]), MATRIX_W'(1));
        chk("sat100", 1, MATRIX_W'(el(res_o[1], elem_off(3, 0))), MATRIX_W'(8'h7F));

        // 3: -128 times -1, then times 0
        for (int k = 0; k < ELEMS; k++) m[8*k +: 8] = 8'h80;
        run_op(m, 8'hFF);
        chk("wrapm128", 0, MATRIX_W'(el(res_o[0], elem_off(0, 4))), MATRIX_W'(8'h80));
        chk("wrapm128_ovf", 0, MATRIX_W'(ovf_o[0]), MATRIX_W'(1));
        chk("satm128", 3, MATRIX_W'(el(res_o[3], elem_off(4, 1))), MATRIX_W'(8'h7F));
        run_op(m, 8'h00);
        chk("zero", 0, res_o[0], '0);
        chk("zero_ovf", 1, MATRIX_W'(ovf_o[1]), '0);

        // 4: operand change and extra start during RUN are ignored
        for (int k = 0; k < ELEMS; k++) m[8*k +: 8] = 8'(k + 1);
        @(posedge clock); #1;
        matrix_a = m; factor = 8'd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        matrix_a = '0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        count_done(40, c0, c2);
        chk("one_done", 0, MATRIX_W'(c0), MATRIX_W'(1));
        chk("orig_operands", 0, MATRIX_W'(el(res_o[0], elem_off(4, 4))), MATRIX_W'(75));

        // 5: reset in the middle of RUN
        for (int k = 0; k < ELEMS; k++) m[8*k +: 8] = 8'd7;
        @(posedge clock); #1;
        matrix_a = m; factor = 8'd5; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rst_busy", 2, MATRIX_W'(busy_o[2]), '0);
        chk("rst_result", 0, res_o[0], '0);
        count_done(40, c0, c2);
        chk("rst_no_done_l5", 0, MATRIX_W'(c0), '0);
        chk("rst_no_done_l1", 2, MATRIX_W'(c2), '0);

        // random single ops
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < ELEMS; k++) m[8*k +: 8] = 8'($urandom);
            run_op(m, (n % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom));
        end

        // 6: start held high, operands changing every cycle
        @(posedge clock); #1;
        start = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge clock);
            for (int i = 0; i < NI; i++) if (done_o[i]) dt[i].push_back(c);
            @(posedge clock); #1;
            for (int k = 0; k < ELEMS; k++) matrix_a[8*k +: 8] = 8'($urandom);
            factor = 8'($urandom);
        end
        start = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk("held_pulses", i, MATRIX_W'(dt[i].size() >= 2), MATRIX_W'(1));
            for (int j = 1; j < dt[i].size(); j++)
                chk("held_spacing", i, MATRIX_W'(dt[i][j] - dt[i][j-1]), MATRIX_W'(SPACING[i]));
        end
        repeat (40) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
